// File: rtl/ma_filter_pkg.sv
// Shared constants and types for the moving-average filter chain.
package ma_filter_pkg;

    localparam int DW     = 16;
    localparam int LOG2_R = 3;
    localparam int DIFF_W = DW + 1;
    localparam int ACC_W  = DW + LOG2_R + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIMED = 2'd1,
        RUN    = 2'd2
    } interp_state_t;

endpackage

// File: rtl/ma_linear_interp.sv
// Linear-interpolating up-converter: one input sample per 2**LOG2_R output beats.
// Optional rounding: define MA_LINEAR_INTERP_ROUND_EN for round-half-up with
// saturation; otherwise q truncates toward -inf.
//
// state  | meaning
// IDLE   | no sample held; next accepted sample becomes x_prev
// PRIMED | x_prev held; next accepted sample starts a segment
// RUN    | emitting interpolated beats k = 0 .. R-1 between x_prev and x_cur
module ma_linear_interp #(
    parameter int DW     = ma_filter_pkg::DW,
    parameter int LOG2_R = ma_filter_pkg::LOG2_R
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] q
);
    import ma_filter_pkg::*;

    localparam int W_DIFF = DW + 1;
    localparam int W_ACC  = DW + LOG2_R + 1;
    localparam logic [LOG2_R-1:0] K_LAST = LOG2_R'((1 << LOG2_R) - 1);

    interp_state_t              r_state;
    logic signed [DW-1:0]       r_x_prev;
    logic signed [DW-1:0]       r_x_cur;
    logic signed [W_DIFF-1:0]   r_diff;
    logic signed [W_ACC-1:0]    r_acc;
    logic [LOG2_R-1:0]          r_k;

    logic                       w_last;
    logic                       w_in_acc;
    logic                       w_out_acc;
    logic signed [DW-1:0]       w_base;
    logic signed [W_DIFF-1:0]   w_diff_new;
    logic signed [W_ACC-1:0]    w_acc_load;
    logic signed [W_ACC-1:0]    w_diff_ext;

    // Handshakes and the start point of the next segment. A new segment starts
    // from x_prev when primed, or from x_cur when chained directly out of RUN.
    always_comb begin
        w_last     = (r_k == K_LAST);
        out_valid  = (r_state == RUN);
        in_ready   = (r_state != RUN) | (w_last & out_ready);
        w_in_acc   = in_valid & in_ready;
        w_out_acc  = out_valid & out_ready;
        w_base     = (r_state == RUN) ? r_x_cur : r_x_prev;
        w_diff_new = {d[DW-1], d} - {w_base[DW-1], w_base};
        w_acc_load = {w_base[DW-1], w_base, {LOG2_R{1'b0}}};
        w_diff_ext = {{LOG2_R{r_diff[W_DIFF-1]}}, r_diff};
    end

    // Control FSM and datapath share one register process so that state and
    // accumulator always change together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_x_prev <= '0;
            r_x_cur  <= '0;
            r_diff   <= '0;
            r_acc    <= '0;
            r_k      <= '0;
        end else if (flush) begin
            r_state  <= IDLE;
            r_x_prev <= '0;
            r_x_cur  <= '0;
            r_diff   <= '0;
            r_acc    <= '0;
            r_k      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_acc) begin
                        r_x_prev <= d;
                        r_state  <= PRIMED;
                    end
                end
                PRIMED: begin
                    if (w_in_acc) begin
                        r_x_cur <= d;
                        r_diff  <= w_diff_new;
                        r_acc   <= w_acc_load;
                        r_k     <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_out_acc) begin
                        if (w_last) begin
                            r_x_prev <= r_x_cur;
                            r_k      <= '0;
                            if (w_in_acc) begin
                                r_x_cur <= d;
                                r_diff  <= w_diff_new;
                                r_acc   <= w_acc_load;
                            end else begin
                                r_acc   <= r_acc + w_diff_ext;
                                r_state <= PRIMED;
                            end
                        end else begin
                            r_acc <= r_acc + w_diff_ext;
                            r_k   <= r_k + LOG2_R'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MA_LINEAR_INTERP_ROUND_EN
    localparam logic signed [W_ACC:0] RND_HALF = (W_ACC+1)'(1 << (LOG2_R - 1));
    localparam logic signed [W_ACC:0] SAT_MAX  = (W_ACC+1)'((1 << (DW - 1)) - 1);
    localparam logic signed [W_ACC:0] SAT_MIN  = -SAT_MAX - (W_ACC+1)'(1);

    logic signed [W_ACC:0] w_rnd_sum;
    logic signed [W_ACC:0] w_rnd_shr;

    // Round half up on a one-bit-wider adder, then clamp to the sample range.
    always_comb begin
        w_rnd_sum = {r_acc[W_ACC-1], r_acc} + RND_HALF;
        w_rnd_shr = w_rnd_sum >>> LOG2_R;
        if (w_rnd_shr > SAT_MAX)
            q = SAT_MAX[DW-1:0];
        else if (w_rnd_shr < SAT_MIN)
            q = SAT_MIN[DW-1:0];
        else
            q = w_rnd_shr[DW-1:0];
    end
`else
    logic w_unused;

    // Floor division by R: the accumulator always stays between two samples,
    // so the selected bits never overflow DW.
    always_comb begin
        q        = r_acc[DW+LOG2_R-1:LOG2_R];
        w_unused = ^{r_acc[W_ACC-1], r_acc[LOG2_R-1:0]};
    end
`endif

endmodule

// File: tb/tb_ma_linear_interp.sv
// Scoreboard bench for ma_linear_interp (LOG2_R = 3).
module tb_ma_linear_interp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] d;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int beat = 0;

    logic signed [15:0] sb[$];

    ma_linear_interp #(.DW(16), .LOG2_R(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted output beat is compared against the queue head.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            beat++;
            last_cyc = cyc;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat %0d: got q=%0d, none expected", beat, $signed(q));
            end else begin
                logic signed [15:0] exp_q;
                exp_q = sb.pop_front();
                if ($signed(q) !== exp_q) begin
                    errors++;
                    $display("FAIL q_beat %0d: got %0d, expected %0d", beat, $signed(q), exp_q);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
        end
    endtask

    task automatic push(input int v);
        sb.push_back(16'(v));
    endtask

    // Present one sample and hold it until the handshake completes.
    task automatic send(input int v);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        d = 16'(v);
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready, expected accept of %0d", v);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic ov_seen;
        int exp3[8];
        int exp5[8];
`ifdef MA_LINEAR_INTERP_ROUND_EN
        exp3 = '{0, 0, -1, -1, -1, -2, -2, -3};
        exp5 = '{32767, 24575, 16383, 8191, 0, -8192, -16384, -24576};
`else
        exp3 = '{0, -1, -1, -2, -2, -2, -3, -3};
        exp5 = '{32767, 24575, 16383, 8191, -1, -8193, -16385, -24577};
`endif
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; d = '0; out_ready = 1'b1;
        #2;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_q", int'($signed(q)), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: async reset mid-RUN, then a lone input produces nothing
        push(0); push(10);
        send(0); send(80);
        @(negedge clk); @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrun_reset_out_valid", int'(out_valid), 0);
        chk("midrun_reset_q", int'($signed(q)), 0);
        chk("midrun_reset_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(55);
        ov_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        chk("single_input_no_output", int'(ov_seen), 0);
        chk("primed_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        do_flush();

        // 2: ramp, chained segment without bubble
        for (int k = 0; k < 16; k++) push(10 * k);
        send(0); send(80);
        c0 = cyc;
        send(160);
        drain();
        chk("ramp_no_bubble_span", last_cyc - c0, 15);
        do_flush();

        // 3: negative fractional slope
        for (int k = 0; k < 8; k++) push(exp3[k]);
        send(0); send(-3);
        drain();
        do_flush();

        // 4: backpressure at k=3
        for (int k = 0; k < 8; k++) push(10 * k);
        send(0); send(80);
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_q", int'($signed(q)), 30);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        do_flush();

        // 5: full-scale swing and the following segment
        for (int k = 0; k < 8; k++) push(exp5[k]);
        for (int k = 0; k < 8; k++) push(-32768 + 4096 * k);
        send(32767); send(-32768); send(0);
        drain();
        do_flush();

        // 6: flush at k=4 with a pending input, then clean restart
        for (int k = 0; k < 5; k++) push(10 * k);
        send(0); send(80);
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1; d = 16'(999);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_q", int'($signed(q)), 0);
        chk("flush_in_ready", int'(in_ready), 1);
        drain();
        for (int k = 0; k < 8; k++) push(8 + k);
        send(8); send(16);
        drain();
        repeat (3) @(posedge clk);
        chk("final_scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
